// File: rtl/mips_muldiv_unit_if.sv
// Handshake and result bundle between the MIPS control path and the HI/LO multiply/divide unit.
interface mips_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, abort,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, abort,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit (restoring divide, shift-add multiply).
// Define MULDIV_FAST_MULT_EN to commit MULT/MULTU in a single cycle with a combinational multiplier.
module mips_muldiv_unit #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               reset_n,
  mips_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t state, state_next;

  logic             busy, commit, accept, launch_iter, signed_op;
  logic [CW-1:0]    cnt;
  logic             is_div, b_zero, neg_res, neg_rem;
  logic [WIDTH-1:0] a_orig, b_reg, p_hi, p_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh, rem_diff, mac;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    accept    = bus.start && !bus.abort && (state == IDLE);
`ifdef MULDIV_FAST_MULT_EN
    launch_iter = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    fast_prod   = {{WIDTH{signed_op & bus.a[WIDTH-1]}}, bus.a} *
                  {{WIDTH{signed_op & bus.b[WIDTH-1]}}, bus.b};
`else
    launch_iter = !bus.op[2];
`endif
  end

  // One iteration of either algorithm on the shared {p_hi,p_lo} register pair, plus sign fix-up.
  always_comb begin
    rem_sh   = {p_hi, p_lo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_reg};
    rem_ge   = (rem_sh >= {1'b0, b_reg});
    mac      = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
    prod_fix = neg_res ? -{p_hi, p_lo} : {p_hi, p_lo};
    q_fix    = neg_res ? -p_lo : p_lo;
    r_fix    = neg_rem ? -p_hi : p_hi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && launch_iter) state_next = CALC;
      CALC: begin
        if (bus.abort)        state_next = IDLE;
        else if (cnt == LAST) state_next = SIGN;
      end
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    commit = (state == SIGN) && !bus.abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      a_orig  <= '0;
      b_reg   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        dbz_q   <= 1'b0;
        cnt     <= '0;
        is_div  <= bus.op[1];
        b_zero  <= (bus.b == '0);
        a_orig  <= bus.a;
        neg_res <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_rem <= signed_op && bus.a[WIDTH-1];
        p_hi    <= '0;
        // Divide shifts the dividend out of p_lo; multiply shifts the multiplier out of p_lo.
        p_lo    <= bus.op[1] ? a_mag : b_mag;
        b_reg   <= bus.op[1] ? b_mag : a_mag;
        case (bus.op)
          OP_MTHI: begin hi_q <= bus.a; done_q <= 1'b1; end
          OP_MTLO: begin lo_q <= bus.a; done_q <= 1'b1; end
          OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
            {hi_q, lo_q} <= fast_prod;
            done_q       <= 1'b1;
`endif
          end
          OP_DIV, OP_DIVU: ;
          default: done_q <= 1'b1;
        endcase
      end else if (state == CALC && !bus.abort) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          p_hi <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          p_lo <= {p_lo[WIDTH-2:0], rem_ge};
        end else begin
          {p_hi, p_lo} <= {mac, p_lo[WIDTH-1:1]};
        end
      end else if (commit) begin
        done_q <= 1'b1;
        if (is_div && b_zero) begin
          lo_q  <= '1;
          hi_q  <= a_orig;
          dbz_q <= 1'b1;
        end else if (is_div) begin
          lo_q <= q_fix;
          hi_q <= r_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
